conv_tempo_seq: RTL and testbench



---
 rtl/conv_tempo_pkg.sv | 55 +++++
 rtl/conv_tempo_passo.sv | 14 +
 rtl/conv_tempo_seq.sv | 109 ++++++++++
 tb/tb_conv_tempo_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/conv_tempo_pkg.sv
// Shared constants, state encoding and stage-selection helpers for the
// sequential seconds-to-calendar converter.
package conv_tempo_pkg;

    localparam int W  = 32;
    localparam int QW = 8;

    localparam logic [W-1:0] ANO_SEG  = 32'd31536000;
    localparam logic [W-1:0] MES_SEG  = 32'd2592000;
    localparam logic [W-1:0] DIA_SEG  = 32'd86400;
    localparam logic [W-1:0] HORA_SEG = 32'd3600;
    localparam logic [W-1:0] MIN_SEG  = 32'd60;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ANOS  = 3'd1,
        MES   = 3'd2,
        DIAS  = 3'd3,
        HORAS = 3'd4,
        MIN   = 3'd5
    } estado_t;

    function automatic logic [W-1:0] unidade(estado_t s);
        case (s)
            ANOS:    return ANO_SEG;
            MES:     return MES_SEG;
            DIAS:    return DIA_SEG;
            HORAS:   return HORA_SEG;
            default: return MIN_SEG;
        endcase
    endfunction

    // Quotient slot owned by each stage; IDLE maps to a slot that is never bumped.
    function automatic logic [2:0] indice(estado_t s);
        case (s)
            ANOS:    return 3'd0;
            MES:     return 3'd1;
            DIAS:    return 3'd2;
            HORAS:   return 3'd3;
            MIN:     return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

    function automatic estado_t proximo(estado_t s);
        case (s)
            ANOS:    return MES;
            MES:     return DIAS;
            DIAS:    return HORAS;
            HORAS:   return MIN;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_tempo_passo.sv
// Shared compare-subtract step: one instance serves every stage of the converter.
import conv_tempo_pkg::*;

module conv_tempo_passo (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] unit,
    output logic         ge,
    output logic [W-1:0] rem_sub
);

    assign ge      = (rem >= unit);
    assign rem_sub = rem - unit;

endmodule

// File: rtl/conv_tempo_seq.sv
// Sequential seconds -> anos/meses/dias/horas/minutos/segundos converter.
// Optional abort input enabled by defining CONV_TEMPO_ABORT_EN.
import conv_tempo_pkg::*;

module conv_tempo_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  in_seg,
`ifdef CONV_TEMPO_ABORT_EN
    input  logic         cancela,
`endif
    output logic         busy,
    output logic         done,
    output logic [31:0]  anos,
    output logic [31:0]  mes,
    output logic [31:0]  dias,
    output logic [31:0]  horas,
    output logic [31:0]  minutos,
    output logic [31:0]  segundos
);

    estado_t        state_reg;
    logic [W-1:0]   rem_reg;
    logic           ge;
    logic [W-1:0]   rem_sub;
    logic           acc;
    logic           aborta;
    logic [4:0]     inc;

    conv_tempo_passo u_passo (
        .rem     (rem_reg),
        .unit    (unidade(state_reg)),
        .ge      (ge),
        .rem_sub (rem_sub)
    );

    assign acc = (state_reg == IDLE) && start;

`ifdef CONV_TEMPO_ABORT_EN
    assign aborta = (state_reg != IDLE) && cancela;
`else
    assign aborta = 1'b0;
`endif

    // One working quotient per stage; only the active stage may count.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_q
            logic [QW-1:0] q;
            assign inc[gi] = ge && !aborta && (indice(state_reg) == 3'(gi));
            always_ff @(posedge clk) begin
                if (rst || acc) begin
                    q <= '0;
                end else if (inc[gi]) begin
                    q <= q + QW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            anos      <= '0;
            mes       <= '0;
            dias      <= '0;
            horas     <= '0;
            minutos   <= '0;
            segundos  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg   <= in_seg;
                        busy      <= 1'b1;
                        state_reg <= ANOS;
                    end
                end
                default: begin
                    if (aborta) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (ge) begin
                        rem_reg <= rem_sub;
                    end else if (state_reg == MIN) begin
                        // Remainder below one minute is the seconds field.
                        anos      <= W'(g_q[0].q);
                        mes       <= W'(g_q[1].q);
                        dias      <= W'(g_q[2].q);
                        horas     <= W'(g_q[3].q);
                        minutos   <= W'(g_q[4].q);
                        segundos  <= rem_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= proximo(state_reg);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tempo_seq.sv
// Directed self-checking bench for conv_tempo_seq (abort steps when
// CONV_TEMPO_ABORT_EN is defined).
module tb_conv_tempo_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_seg = '0;
`ifdef CONV_TEMPO_ABORT_EN
    logic        cancela = 1'b0;
`endif
    logic        busy, done;
    logic [31:0] anos, mes, dias, horas, minutos, segundos;

    int vectors = 0;
    int miscompares = 0;

    conv_tempo_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_seg   (in_seg),
`ifdef CONV_TEMPO_ABORT_EN
        .cancela  (cancela),
`endif
        .busy     (busy),
        .done     (done),
        .anos     (anos),
        .mes      (mes),
        .dias     (dias),
        .horas    (horas),
        .minutos  (minutos),
        .segundos (segundos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] ea, em, ed, eh, emi, es);
        chk({tag, ".anos"}, anos, ea);
        chk({tag, ".mes"}, mes, em);
        chk({tag, ".dias"}, dias, ed);
        chk({tag, ".horas"}, horas, eh);
        chk({tag, ".minutos"}, minutos, emi);
        chk({tag, ".segundos"}, segundos, es);
    endtask

    // Called at a negedge; start is presented now and sampled at the next edge (E).
    // mid > 0 pulses a spurious start (in_seg=0) that many cycles after E.
    task automatic run(input string tag, input logic [31:0] v, input int exp_lat,
                       input logic [31:0] ea, em, ed, eh, emi, es, input int mid);
        int n;
        int busy_n;
        start  = 1'b1;
        in_seg = v;
        @(negedge clk);
        start  = 1'b0;
        in_seg = 32'hA5A5_0F0F;
        n = 0;
        busy_n = 0;
        while (!done && n < 400) begin
            if (busy) busy_n++;
            if (mid != 0 && n == mid) begin
                start  = 1'b1;
                in_seg = 32'd0;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        chk_outs(tag, ea, em, ed, eh, emi, es);
        $display("run %s in_seg=%0d latency=%0d -> %0d/%0d/%0d/%0d/%0d/%0d",
                 tag, v, n, anos, mes, dias, horas, minutos, segundos);
    endtask

    initial begin
        int saw_done;

        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", {31'd0, busy}, 32'd0);

        run("zero", 32'd0, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("zero.done_one_cycle", {31'd0, done}, 32'd0);

        run("d1h1m1s1", 32'd90061, 8, 0, 0, 1, 1, 1, 1, 0);
        @(negedge clk);
        run("all_ones", 32'd34218061, 10, 1, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        run("max", 32'hFFFF_FFFF, 187, 136, 2, 10, 6, 28, 15, 50);
        // done is high right now: a start in this cycle must be accepted
        run("back2back", 32'd90061, 8, 0, 0, 1, 1, 1, 1, 0);

        // Reset three cycles into a conversion
        @(negedge clk);
        start  = 1'b1;
        in_seg = 32'd90061;
        @(negedge clk);
        start  = 1'b0;
        saw_done = 0;
        repeat (3) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.no_done", 32'(saw_done), 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk_outs("midrst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        run("after_rst", 32'd34218061, 10, 1, 1, 1, 1, 1, 1, 0);

`ifdef CONV_TEMPO_ABORT_EN
        @(negedge clk);
        start  = 1'b1;
        in_seg = 32'd90061;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        cancela = 1'b1;
        @(negedge clk);
        cancela = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        saw_done = 0;
        repeat (12) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(saw_done), 32'd0);
        chk_outs("abort", 1, 1, 1, 1, 1, 1);
        cancela = 1'b1;
        run("abort_idle", 32'd61, 6, 0, 0, 0, 0, 1, 1, 0);
        cancela = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
